// File: rtl/bm_pkg.sv
// bm_pkg: shared bitmap geometry, command/step encodings and sequencer states
package bm_pkg;
  localparam int ROW_W = 24;
  localparam int ROWS  = 64;
  localparam int BM_W  = ROW_W * ROWS;
  localparam int DN_W  = 6;
  localparam int LF_W  = 5;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_SHIFT = 2'b01, OP_SCALE = 2'b10} op_t;
  typedef enum logic [1:0] {ST_NONE, ST_DOWN, ST_LEFT, ST_SCALE} step_t;
  typedef enum logic [2:0] {IDLE, DOWN, LEFT, SCALE, DONE} state_t;
endpackage

// File: rtl/bm_step.sv
// bm_step: one combinational step of the bitmap datapath (none, down1, left1, scale2x)
module bm_step
  import bm_pkg::*;
(
  input  logic [BM_W-1:0] x,
  input  step_t           sel,
  output logic [BM_W-1:0] y
);
  logic [BM_W-1:0] lf, sc;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign lf[r*ROW_W +: ROW_W] = {x[r*ROW_W +: ROW_W-1], 1'b0};
    // upscale sources the top-half rows, low-column quadrant
    for (genvar c = 0; c < ROW_W; c++) begin : g_col
      assign sc[r*ROW_W+c] = x[(ROWS/2 + r/2)*ROW_W + c/2];
    end
  end
  always_comb y = sel == ST_DOWN  ? {{ROW_W{1'b0}}, x[BM_W-1:ROW_W]} :
                  sel == ST_LEFT  ? lf :
                  sel == ST_SCALE ? sc : x;
endmodule

// File: rtl/bm_op_sequencer.sv
// bm_op_sequencer: multi-cycle BMR shift/scale controller owning the working bitmap
module bm_op_sequencer
  import bm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [DN_W-1:0] cmd_down,
  input  logic [LF_W-1:0] cmd_left,
  input  logic [BM_W-1:0] bm_in,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [BM_W-1:0] bm_out,
  output logic            busy
);
  state_t          state, nxt;
  step_t           sel;
  logic [BM_W-1:0] work, step_y;
  logic [DN_W-1:0] dcnt;
  logic [LF_W-1:0] lcnt, lf_clamp;
  logic            accept, is_shift;
  assign accept    = cmd_valid & cmd_ready;
  assign is_shift  = cmd_op == OP_SHIFT;
  assign lf_clamp  = cmd_left >= LF_W'(ROW_W) ? LF_W'(ROW_W) : cmd_left;
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign res_valid = state == DONE;
  assign bm_out    = work;
  bm_step u_step (.x(work), .sel(sel), .y(step_y));
  always_comb begin
    nxt = state;
    sel = ST_NONE;
    case (state)
      IDLE:  if (accept) nxt = cmd_op == OP_SCALE ? SCALE :
                               !is_shift          ? DONE  :
                               cmd_down != '0     ? DOWN  :
                               lf_clamp != '0     ? LEFT  : DONE;
      DOWN:  begin
        sel = ST_DOWN;
        if (dcnt == DN_W'(1)) nxt = lcnt != '0 ? LEFT : DONE;
      end
      LEFT:  begin
        sel = ST_LEFT;
        if (lcnt == LF_W'(1)) nxt = DONE;
      end
      SCALE: begin
        sel = ST_SCALE;
        nxt = DONE;
      end
      DONE:  if (res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      dcnt  <= '0;
      lcnt  <= '0;
    end else begin
      state <= nxt;
      work  <= accept ? bm_in : step_y;
      if (accept) begin
        dcnt <= is_shift ? cmd_down : '0;
        lcnt <= is_shift ? lf_clamp : '0;
      end else begin
        if (state == DOWN) dcnt <= dcnt - DN_W'(1);
        if (state == LEFT) lcnt <= lcnt - LF_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_bm_op_sequencer.sv
// tb_bm_op_sequencer: directed vectors with a result scoreboard checking bitmap and latency
module tb_bm_op_sequencer;
  import bm_pkg::*;
  logic            clk = 0, rst = 1, cmd_valid = 0, res_ready = 1;
  logic [1:0]      cmd_op = 0;
  logic [DN_W-1:0] cmd_down = 0;
  logic [LF_W-1:0] cmd_left = 0;
  logic [BM_W-1:0] bm_in = '0;
  logic            cmd_ready, res_valid, busy;
  logic [BM_W-1:0] bm_out;
  int              vec = 0, errs = 0, cyc = 0;
  logic            seen = 0;
  logic [BM_W-1:0] exp_q[$];
  int              cyc_q[$];

  bm_op_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_down(cmd_down), .cmd_left(cmd_left), .bm_in(bm_in), .res_valid(res_valid),
    .res_ready(res_ready), .bm_out(bm_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk_bm(input string name, input logic [BM_W-1:0] got, input logic [BM_W-1:0] want);
    vec++;
    if (got !== want) begin
      int d = 0;
      for (int i = BM_W - 1; i >= 0; i--) if (got[i] !== want[i]) d = i;
      errs++;
      $display("FAIL %s: got %0d set bits want %0d, first differing bit %0d got %b want %b",
               name, $countones(got), $countones(want), d, got[d], want[d]);
    end
  endtask

  function automatic logic [BM_W-1:0] onebit(input int i);
    logic [BM_W-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (res_valid && !seen) begin
      seen = 1;
      if (exp_q.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL unexpected_result: got res_valid 1 want 0");
      end else begin
        chk_bm("result", bm_out, exp_q.pop_front());
        chk("latency", cyc, cyc_q.pop_front());
      end
    end
    if (!res_valid) seen = 0;
  end

  task automatic issue(input logic [1:0] op, input logic [DN_W-1:0] dn, input logic [LF_W-1:0] lf,
                       input logic [BM_W-1:0] bm, input logic [BM_W-1:0] want, input int lat);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_down = dn; cmd_left = lf; bm_in = bm;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      vec++;
      errs++;
      $display("FAIL accept_timeout: got cmd_ready 0 want 1");
    end else begin
      exp_q.push_back(want);
      cyc_q.push_back(cyc + lat);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vec++;
      errs++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    logic [BM_W-1:0] p, b, e;
    int n;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_bm("reset_bm_out", bm_out, '0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);

    issue(2'b01, 3, 2, onebit(245), onebit(175), 6);
    for (int i = 0; i < 6; i++) begin
      chk("busy_shift", busy, 1);
      @(negedge clk);
    end
    chk("busy_after", busy, 0);
    drain();

    p = {ROWS{24'hA5C3F1}};
    issue(2'b01, 0, 0, p, p, 1); drain();
    issue(2'b11, 5, 7, p, p, 1); drain();
    issue(2'b00, 2, 3, p, p, 1); drain();

    issue(2'b10, 0, 0, onebit(768), onebit(0) | onebit(1) | onebit(24) | onebit(25), 2); drain();
    issue(2'b10, 0, 0, onebit(33*24+3), onebit(54) | onebit(55) | onebit(78) | onebit(79), 2); drain();

    b = '0; b[BM_W-1 -: ROW_W] = '1;
    e = '0; e[ROW_W-1:0] = '1;
    issue(2'b01, 63, 0, b, e, 64); drain();
    issue(2'b01, 0, 31, '1, '0, 25); drain();

    b = '0; b[ROW_W +: ROW_W] = 24'h800001;
    e = '0; e[0 +: ROW_W] = 24'h000002;
    issue(2'b01, 1, 1, b, e, 3); drain();
    b = '0; b[5*ROW_W +: ROW_W] = 24'hC00001;
    e = '0; e[5*ROW_W +: ROW_W] = 24'h800002;
    issue(2'b01, 0, 1, b, e, 2); drain();

    res_ready = 0;
    b = onebit(0);
    issue(2'b01, 0, 1, b, onebit(1), 2);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_res_valid_seen", res_valid, 1);
    cmd_valid = 1; cmd_op = 2'b10; bm_in = onebit(768);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_bm("bp_bm_out_stable", bm_out, onebit(1));
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_res_valid", res_valid, 1);
    end
    cmd_valid = 0;
    res_ready = 1;
    @(negedge clk);
    chk("bp_after_res_valid", res_valid, 0);
    chk("bp_after_cmd_ready", cmd_ready, 1);
    chk_bm("bp_after_bm_hold", bm_out, onebit(1));
    repeat (3) @(negedge clk);
    chk("bp_ignored_cmd", busy, 0);

    issue(2'b01, 0, 10, '1, '0, 11);
    @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_q.delete();
    cyc_q.delete();
    chk("rst_mid_res_valid", res_valid, 0);
    chk_bm("rst_mid_bm_out", bm_out, '0);
    chk("rst_mid_busy_clear", busy, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    repeat (12) @(negedge clk);
    chk("rst_mid_discarded", res_valid, 0);

    issue(2'b00, 0, 0, p, p, 1); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
